adc_spi_cfg: RTL and testbench
==============================

Name: adc_spi_cfg

Overview:
Serial-port configuration sequencer for the LTC2151 ADC: drives ADC_nCS/ADC_SCK/ADC_SDI, samples ADC_SDO, holds ADC_PnS in serial-programming mode.
After reset it waits a power-up delay, then writes a fixed register table.
After init it serves single read/write requests from a host (MCU SPI bridge) via req/ack, so adControl and the MCU share one ADC configuration port.
Runs in the system clock domain, alongside adControl under top.

Parameters:
CLK_DIV, 4, SCK half-period in clk cycles (>=2); SCK = clk/(2*CLK_DIV)
PWRUP_CYC, 1000, clk cycles from reset release to first frame
GAP_CYC, 8, minimum nCS-high cycles between frames

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
start  in  1  1-cycle pulse: rerun init table (ignored unless idle)
host_req  in  1  host request, level; held until host_ack
host_rw  in  1  1=read, 0=write
host_addr  in  7  ADC register address
host_wdata  in  8  write data
host_ack  out  1  1-cycle pulse when the frame completes
host_rdata  out  8  read data, valid with host_ack
busy  out  1  frame or init in progress
init_done  out  1  table fully written; cleared by start
cfg_err  out  1  sticky readback mismatch (see Optional Feature)
ADC_nCS  out  1  chip select, active-low
ADC_SCK  out  1  serial clock, idle low
ADC_SDI  out  1  serial data to ADC
ADC_SDO  in  1  serial data from ADC
ADC_PnS  out  1  constant 0 (serial mode)

Behaviour:
- Reset values: ADC_nCS=1, ADC_SCK=0, ADC_SDI=0, ADC_PnS=0, host_ack=0, host_rdata=0, busy=1, init_done=0, cfg_err=0.
- Frame: 16 bits MSB first = {rw, addr[6:0], data[7:0]}; rw=1 read, data bits then 0.
- Frame timing: nCS falls; after CLK_DIV cycles, each bit = CLK_DIV cycles SCK low + CLK_DIV cycles SCK high. SDI updates when SCK goes low; SDO sampled on the last clk of each SCK-high phase. After bit 0, SCK low for CLK_DIV cycles, then nCS rises. nCS low total = 34*CLK_DIV cycles (136 at default).
- Read data = SDO samples of bits 7..0.
- Init table, in order: (0x00,0x80) soft reset; (0x01,0x00); (0x02,0x00); (0x03,0x00); (0x04,0x00).
- FSM states:
  - PWRUP: count PWRUP_CYC -> INIT_LOAD.
  - INIT_LOAD: load table[idx] -> SHIFT.
  - SHIFT -> GAP.
  - GAP: GAP_CYC cycles, then: idx<4 -> INIT_LOAD (idx+1); idx==4 -> set init_done -> IDLE; host frame -> IDLE with host_ack.
  - IDLE: busy=0. host_req -> HOST_LOAD -> SHIFT. start -> INIT_LOAD with idx=0, init_done=0.
- host_ack pulses on the first GAP->IDLE cycle. host_rdata updates with it for reads; unchanged for writes.
- Priority: start beats host_req in the same IDLE cycle. host_req during busy waits; it is never dropped.
- start while busy: ignored.
- Soft-reset write (0x00,0x80) is never read back.
- rst_n asserted mid-frame: all outputs return to reset values immediately (nCS high, frame aborted); the sequence restarts at PWRUP.
- host_req deasserted before ack: no effect once the frame has started; ack still pulses.

Optional Feature:
ADC_CFG_VERIFY_EN
- Defined: after each init write except addr 0x00, issue a read frame to the same address (GAP between frames). Mismatch sets cfg_err (sticky until reset or start); the sequence continues.
- Undefined: no readback frames; cfg_err tied 0.

Test Plan:
- Reset release, defaults -> first nCS fall at cycle 1000; 5 frames; SDI of frame 1 = 0x0080; init_done=1 after 5th GAP; busy falls with it.
- Bit timing at CLK_DIV=4 -> nCS low exactly 136 cycles; 16 SCK rising edges; SDI stable >=4 cycles around each rising edge.
- Host read addr 0x03 with model returning 0xA5 on SDO -> frame 0x8300; host_ack 1 cycle; host_rdata=0xA5.
- host_req and start in the same idle cycle -> init table runs first; host frame follows; host_ack only after it.
- rst_n low at bit 7 of frame 3 -> nCS=1 and SCK=0 same cycle; after release, restarts with PWRUP and frame 1.
- VERIFY_EN, model returns 0x01 for addr 0x02 -> 9 frames total; cfg_err=1; init_done=1.

Source files
------------

// File: rtl/adc_spi_cfg.sv
// rtl/adc_spi_cfg.sv - LTC2151 serial-port configuration sequencer
//
// After reset it waits PWRUP_CYC clocks, writes the fixed register table
// (0x00<-0x80 soft reset, then 0x01..0x04 <- 0x00), then serves single
// host read/write frames through a req/ack handshake.
//
// Ports:
//   clk, rst_n                  system clock, asynchronous active-low reset
//   start                       pulse: rerun the init table (only honoured when idle)
//   host_req/rw/addr/wdata      host request, held until host_ack
//   host_ack, host_rdata        1-cycle completion pulse, read data valid with it
//   busy, init_done, cfg_err    status
//   ADC_nCS/SCK/SDI/SDO/PnS     ADC serial configuration port (PnS tied 0)
//
// Optional build macro ADC_CFG_VERIFY_EN: every init write except address 0x00
// is followed by a readback frame; a mismatch sets the sticky cfg_err.
module adc_spi_cfg #(
    parameter int CLK_DIV   = 4,
    parameter int PWRUP_CYC = 1000,
    parameter int GAP_CYC   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       host_req,
    input  logic       host_rw,
    input  logic [6:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_ack,
    output logic [7:0] host_rdata,
    output logic       busy,
    output logic       init_done,
    output logic       cfg_err,
    output logic       ADC_nCS,
    output logic       ADC_SCK,
    output logic       ADC_SDI,
    input  logic       ADC_SDO,
    output logic       ADC_PnS
);

    localparam int CW = $clog2(PWRUP_CYC + GAP_CYC) + 1;
    localparam int DW = $clog2(CLK_DIV) + 1;
    localparam logic [2:0] LAST_IDX = 3'd4;

    typedef enum logic [2:0] {
        PWRUP, INIT_LOAD, HOST_LOAD, SHIFT, GAP, IDLE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;         // power-up and gap counter
    logic [DW-1:0] div;         // clk count inside one SCK half-period
    logic [5:0]    half;        // 0 lead-in, 1..32 bit halves (odd=low, even=high), 33 tail
    logic [2:0]    idx;         // init table index
    logic          vphase;      // current init frame is a readback
    logic          host_frame;
    logic          frame_rd;
    logic [15:0]   shreg;
    logic [7:0]    rx;

    // Register table: address equals index, only the soft reset carries data.
    function automatic logic [7:0] tbl_data(input logic [2:0] i);
        return (i == 3'd0) ? 8'h80 : 8'h00;
    endfunction

    assign ADC_PnS = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PWRUP;
            cnt        <= '0;
            div        <= '0;
            half       <= '0;
            idx        <= '0;
            vphase     <= 1'b0;
            host_frame <= 1'b0;
            frame_rd   <= 1'b0;
            shreg      <= '0;
            rx         <= '0;
            host_ack   <= 1'b0;
            host_rdata <= '0;
            busy       <= 1'b1;
            init_done  <= 1'b0;
            cfg_err    <= 1'b0;
            ADC_nCS    <= 1'b1;
            ADC_SCK    <= 1'b0;
            ADC_SDI    <= 1'b0;
        end else begin
            host_ack <= 1'b0;
            case (state)
                PWRUP: begin
                    // Leaves one cycle early so nCS falls on clock PWRUP_CYC.
                    if (cnt == CW'(PWRUP_CYC - 2)) begin
                        cnt   <= '0;
                        state <= INIT_LOAD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                INIT_LOAD: begin
                    shreg      <= {vphase, 4'b0000, idx, vphase ? 8'h00 : tbl_data(idx)};
                    host_frame <= 1'b0;
                    ADC_nCS    <= 1'b0;
                    div        <= '0;
                    half       <= '0;
                    state      <= SHIFT;
                end
                HOST_LOAD: begin
                    shreg      <= {host_rw, host_addr, host_rw ? 8'h00 : host_wdata};
                    host_frame <= 1'b1;
                    frame_rd   <= host_rw;
                    ADC_nCS    <= 1'b0;
                    div        <= '0;
                    half       <= '0;
                    state      <= SHIFT;
                end
                SHIFT: begin
                    if (div != DW'(CLK_DIV - 1)) begin
                        div <= div + 1'b1;
                    end else begin
                        div  <= '0;
                        half <= half + 6'd1;
                        if (half == 6'd33) begin
                            ADC_nCS <= 1'b1;
                            ADC_SDI <= 1'b0;
                            cnt     <= '0;
                            state   <= GAP;
                        end else if (half[0]) begin
                            ADC_SCK <= 1'b1;
                        end else begin
                            // End of lead-in or of a high phase: sample, drop SCK, next bit.
                            ADC_SCK <= 1'b0;
                            if (half != 6'd0) rx <= {rx[6:0], ADC_SDO};
                            if (half != 6'd32) begin
                                ADC_SDI <= shreg[15];
                                shreg   <= {shreg[14:0], 1'b0};
                            end
                        end
                    end
                end
                GAP: begin
                    if (cnt != CW'(GAP_CYC - 1)) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (host_frame) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            host_ack <= 1'b1;
                            if (frame_rd) host_rdata <= rx;
                        end else begin
`ifdef ADC_CFG_VERIFY_EN
                            if (vphase && rx != tbl_data(idx)) cfg_err <= 1'b1;
                            if (!vphase && idx != 3'd0) begin
                                vphase <= 1'b1;
                                state  <= INIT_LOAD;
                            end else
`endif
                            if (idx == LAST_IDX) begin
                                vphase    <= 1'b0;
                                init_done <= 1'b1;
                                busy      <= 1'b0;
                                state     <= IDLE;
                            end else begin
                                vphase <= 1'b0;
                                idx    <= idx + 3'd1;
                                state  <= INIT_LOAD;
                            end
                        end
                    end
                end
                IDLE: begin
                    if (start) begin
                        idx       <= '0;
                        vphase    <= 1'b0;
                        init_done <= 1'b0;
                        cfg_err   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= INIT_LOAD;
                    end else if (host_req) begin
                        busy  <= 1'b1;
                        state <= HOST_LOAD;
                    end
                end
                default: state <= PWRUP;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_cfg.sv
// tb/tb_adc_spi_cfg.sv - self-checking bench for adc_spi_cfg with a behavioural ADC serial-port model
`timescale 1ns/1ps
module tb_adc_spi_cfg;

    localparam int CLK_DIV   = 4;
    localparam int PWRUP_CYC = 1000;
`ifdef ADC_CFG_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       host_req = 1'b0;
    logic       host_rw = 1'b0;
    logic [6:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic       ADC_SDO = 1'b0;
    logic       host_ack, busy, init_done, cfg_err;
    logic [7:0] host_rdata;
    logic       ADC_nCS, ADC_SCK, ADC_SDI, ADC_PnS;

    adc_spi_cfg dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .host_req(host_req), .host_rw(host_rw), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata),
        .busy(busy), .init_done(init_done), .cfg_err(cfg_err),
        .ADC_nCS(ADC_nCS), .ADC_SCK(ADC_SCK), .ADC_SDI(ADC_SDI), .ADC_SDO(ADC_SDO), .ADC_PnS(ADC_PnS)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ADC model: register file, frame capture, timing observation
    logic [7:0]  regs [128];
    logic [7:0]  ref_mem [128];
    logic [15:0] frames [$];
    logic [15:0] exp_q [$];
    logic [15:0] cap = '0;
    logic [7:0]  rd_val = '0;
    bit          override_a2 = 1'b0;
    int mcyc = 0, frame_no = 0, bit_cnt = 0, low_len = 0, last_sdi_chg = 0, last_rise = 0;
    logic prev_ncs = 1'b1, prev_sck = 1'b0, prev_sdi = 1'b0, sdi_viol = 1'b0, rise_seen = 1'b0;

    always @(negedge clk) begin
        mcyc++;
        if (!rst_n) begin
            prev_ncs = 1'b1;
            prev_sck = 1'b0;
            prev_sdi = 1'b0;
            ADC_SDO  = 1'b0;
        end else begin
            if (ADC_SDI !== prev_sdi) begin
                if (!ADC_nCS && rise_seen && (mcyc - last_rise < CLK_DIV)) sdi_viol = 1'b1;
                last_sdi_chg = mcyc;
            end
            if (prev_ncs && !ADC_nCS) begin
                frame_no++;
                bit_cnt = 0; low_len = 0; cap = '0; sdi_viol = 1'b0; rise_seen = 1'b0;
            end
            if (!ADC_nCS) begin
                low_len++;
                if (!prev_sck && ADC_SCK) begin
                    if (mcyc - last_sdi_chg < CLK_DIV) sdi_viol = 1'b1;
                    cap = {cap[14:0], ADC_SDI};
                    bit_cnt++;
                    rise_seen = 1'b1;
                    last_rise = mcyc;
                    if (bit_cnt == 8)
                        rd_val = (override_a2 && cap[6:0] == 7'h02) ? 8'h01 : regs[cap[6:0]];
                    if (bit_cnt >= 9 && bit_cnt <= 16) ADC_SDO = rd_val[3'(16 - bit_cnt)];
                end
            end
            if (!prev_ncs && ADC_nCS) begin
                check("ncs_low_cycles", low_len, 34 * CLK_DIV);
                check("sck_rises", bit_cnt, 16);
                check("sdi_stable", {31'd0, sdi_viol}, 0);
                if (bit_cnt == 16 && !cap[15]) regs[cap[14:8]] = cap[7:0];
                frames.push_back(cap);
                ADC_SDO = 1'b0;
            end
            prev_ncs = ADC_nCS;
            prev_sck = ADC_SCK;
            prev_sdi = ADC_SDI;
        end
    end

    // Expected init frame list from the table rules
    task automatic build_init_list();
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({1'b0, 7'(i), (i == 0) ? 8'h80 : 8'h00});
            if (VERIFY && i != 0) exp_q.push_back({1'b1, 7'(i), 8'h00});
        end
    endtask

    task automatic apply_init_ref();
        for (int i = 0; i < 5; i++) ref_mem[i] = (i == 0) ? 8'h80 : 8'h00;
    endtask

    task automatic compare_frames(input string tag);
        logic [15:0] f;
        check({tag, "_frame_count"}, frames.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            f = (i < frames.size()) ? frames[i] : 16'hxxxx;
            check($sformatf("%s_frame%0d", tag, i), f, exp_q[i]);
        end
        frames.delete();
    endtask

    task automatic expect_first_fall(input string tag);
        int cyc = 0;
        bit seen = 0;
        for (int n = 1; n <= PWRUP_CYC + 50; n++) begin
            @(negedge clk);
            if (!ADC_nCS) begin cyc = n; seen = 1; break; end
        end
        check({tag, "_first_ncs_fall_cycle"}, seen ? cyc : -1, PWRUP_CYC);
        check({tag, "_busy_during_init"}, busy, 1);
    endtask

    task automatic expect_init(input logic exp_err, input string tag);
        bit got = 0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (init_done) begin got = 1; break; end
        end
        check({tag, "_init_done"}, got, 1);
        check({tag, "_busy_low_with_done"}, busy, 0);
        check({tag, "_cfg_err"}, cfg_err, exp_err);
        build_init_list();
        compare_frames(tag);
        apply_init_ref();
    endtask

    // mode 0 plain, 1 pulse start mid-frame, 2 drop req (and scramble inputs) mid-frame
    task automatic host_op(input logic rw, input logic [6:0] addr, input logic [7:0] wd, input int mode,
                           output logic [15:0] frame, output logic [7:0] rd);
        bit got = 0, acted = 0;
        frame = 'x;
        rd = 'x;
        @(negedge clk);
        host_rw = rw; host_addr = addr; host_wdata = wd; host_req = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (host_ack) begin got = 1; rd = host_rdata; break; end
            if (!ADC_nCS && !acted) begin
                acted = 1;
                if (mode == 1) start = 1'b1;
                if (mode == 2) begin
                    host_req = 1'b0; host_addr = ~addr; host_wdata = ~wd; host_rw = ~rw;
                end
            end
        end
        host_req = 1'b0;
        start = 1'b0;
        check("host_ack_seen", got, 1);
        @(negedge clk);
        check("host_ack_one_cycle", host_ack, 0);
        check("frames_per_op", frames.size(), 1);
        if (frames.size() > 0) frame = frames[0];
        frames.delete();
    endtask

    typedef struct {
        logic        rw;
        logic [6:0]  addr;
        logic [7:0]  wdata;
        logic        preset;
        logic [7:0]  adc_val;
        logic [15:0] exp_frame;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [15:0] f;
        logic [7:0]  r, exp_rd, wd;
        logic [6:0]  a;
        logic        rw, got, idone;
        int          base;

        vecs[0] = '{1'b1, 7'h03, 8'h00, 1'b1, 8'hA5, 16'h8300, 8'hA5};
        vecs[1] = '{1'b0, 7'h01, 8'h5A, 1'b0, 8'h00, 16'h015A, 8'hA5};
        vecs[2] = '{1'b1, 7'h01, 8'h00, 1'b0, 8'h00, 16'h8100, 8'h5A};
        vecs[3] = '{1'b1, 7'h7F, 8'h00, 1'b1, 8'h3C, 16'hFF00, 8'h3C};
        vecs[4] = '{1'b0, 7'h7F, 8'hFF, 1'b0, 8'h00, 16'h7FFF, 8'h3C};
        vecs[5] = '{1'b1, 7'h7F, 8'h00, 1'b0, 8'h00, 16'hFF00, 8'hFF};
        vecs[6] = '{1'b1, 7'h00, 8'h00, 1'b1, 8'h00, 16'h8000, 8'h00};
        vecs[7] = '{1'b0, 7'h2A, 8'hC3, 1'b0, 8'h00, 16'h2AC3, 8'h00};
        vecs[8] = '{1'b1, 7'h55, 8'h00, 1'b1, 8'h81, 16'hD500, 8'h81};
        for (int i = 0; i < 128; i++) begin regs[i] = 8'h00; ref_mem[i] = 8'h00; end

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ncs", ADC_nCS, 1);
        check("rst_sck", ADC_SCK, 0);
        check("rst_sdi", ADC_SDI, 0);
        check("rst_pns", ADC_PnS, 0);
        check("rst_ack", host_ack, 0);
        check("rst_rdata", host_rdata, 0);
        check("rst_busy", busy, 1);
        check("rst_init_done", init_done, 0);
        check("rst_cfg_err", cfg_err, 0);

        // Power-up and init table (readback of addr 2 corrupted when verify is built in)
        override_a2 = VERIFY;
        @(negedge clk);
        rst_n = 1'b1;
        expect_first_fall("pwrup");
        expect_init(VERIFY, "init");
        override_a2 = 1'b0;

        // Table-driven host frames
        exp_rd = 8'h00;
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].preset) begin
                regs[vecs[i].addr] = vecs[i].adc_val;
                ref_mem[vecs[i].addr] = vecs[i].adc_val;
            end
            host_op(vecs[i].rw, vecs[i].addr, vecs[i].wdata, 0, f, r);
            check($sformatf("vec%0d_frame", i), f, vecs[i].exp_frame);
            check($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rdata);
            if (!vecs[i].rw) ref_mem[vecs[i].addr] = vecs[i].wdata;
            exp_rd = vecs[i].exp_rdata;
        end

        // start while busy is ignored
        host_op(1'b0, 7'h10, 8'h77, 1, f, r);
        check("start_busy_frame", f, 16'h1077);
        check("start_busy_rdata_kept", r, exp_rd);
        check("start_busy_init_done", init_done, 1);
        ref_mem[7'h10] = 8'h77;

        // host_req dropped once the frame has begun
        host_op(1'b1, 7'h10, 8'h00, 2, f, r);
        check("drop_req_frame", f, 16'h9000);
        check("drop_req_rdata", r, 8'h77);
        exp_rd = 8'h77;

        // Randomized host traffic against the reference register image
        for (int k = 0; k < 12; k++) begin
            rw = 1'($urandom_range(0, 1));
            a  = 7'($urandom_range(0, 127));
            wd = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 5)) @(negedge clk);
            if (rw) exp_rd = ref_mem[a];
            host_op(rw, a, wd, 0, f, r);
            check($sformatf("rand%0d_frame", k), f,
                  (32'(rw) << 15) | (32'(a) << 8) | (rw ? 32'd0 : 32'(wd)));
            check($sformatf("rand%0d_rdata", k), r, exp_rd);
            if (!rw) ref_mem[a] = wd;
        end

        // start and host_req in the same idle cycle: init table first
        @(negedge clk);
        start = 1'b1; host_req = 1'b1; host_rw = 1'b1; host_addr = 7'h04; host_wdata = 8'h00;
        @(negedge clk);
        start = 1'b0;
        check("start_first_busy", busy, 1);
        check("start_clears_init_done", init_done, 0);
        got = 0; idone = 0; r = 'x;
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk);
            if (host_ack) begin got = 1; idone = init_done; r = host_rdata; break; end
        end
        host_req = 1'b0;
        check("start_host_ack_seen", got, 1);
        check("start_host_ack_after_init", idone, 1);
        check("start_host_rdata", r, 8'h00);
        check("start_rerun_cfg_err", cfg_err, 0);
        build_init_list();
        exp_q.push_back(16'h8400);
        compare_frames("start_host");
        apply_init_ref();

        // Reset asserted during bit 7 of init frame 3
        base = frame_no;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        got = 0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (frame_no == base + 3 && bit_cnt >= 9 && !ADC_nCS) begin got = 1; break; end
        end
        check("reach_frame3_bit7", got, 1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_ncs", ADC_nCS, 1);
        check("abort_sck", ADC_SCK, 0);
        check("abort_sdi", ADC_SDI, 0);
        check("abort_busy", busy, 1);
        check("abort_init_done", init_done, 0);
        repeat (3) @(negedge clk);
        frames.delete();
        rst_n = 1'b1;
        expect_first_fall("restart");
        expect_init(1'b0, "restart");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
